control_riego: RTL and testbench

//  Watering-decision stage that drives the alarm melody stage's 'regar' input (and the pump).

---
 rtl/control_riego.sv | 140 ++++++++++++++
 tb/tb_control_riego.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_riego.sv
// control_riego: watering-decision stage.
// It samples the asynchronous soil comparator 'seco' through a 2-flop synchroniser and
// debounces the result. A three-state sequencer (IDLE -> REGANDO -> ESPERA) decides
// when to water, enforcing a minimum time, a maximum time and a cooldown.
// Interface semantics: there is no handshake. 'regar' is a registered level that is high
// exactly while 'estado' == REGANDO, and downstream stages sample it every cycle.
// 'estado' also serves as the debug view of the FSM state register.
module control_riego #(
    parameter int unsigned DEBOUNCE_CYC  = 500_000,
    parameter int unsigned RIEGO_MIN_CYC = 60_000_000,
    parameter int unsigned RIEGO_MAX_CYC = 600_000_000,
    parameter int unsigned ESPERA_CYC    = 300_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       seco,
    input  logic       habilitar,
    output logic       regar,
    output logic [1:0] estado,
    output logic       falla_sensor,
    output logic [7:0] num_riegos
);

    // State encoding; 3 is unused and folds back to IDLE.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REGANDO = 2'd1;
    localparam logic [1:0] ST_ESPERA  = 2'd2;

    // Last count value of each timed window (windows are counted from 0).
    localparam logic [31:0] DB_LAST  = 32'(DEBOUNCE_CYC - 1);
    localparam logic [31:0] MIN_LAST = 32'(RIEGO_MIN_CYC - 1);
    localparam logic [31:0] MAX_LAST = 32'(RIEGO_MAX_CYC - 1);
    localparam logic [31:0] ESP_LAST = 32'(ESPERA_CYC - 1);

    localparam logic [7:0] NUM_SAT = 8'hFF;

    // Synchroniser and debounce state
    logic        seco_m;
    logic        seco_s;
    logic        seco_db;
    logic [31:0] db_cnt;

    // Sequencer state
    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [31:0] t;
    logic        falla_nx;
    logic [7:0]  num_nx;
    logic        t_clr;

    // Two-flop synchroniser for the asynchronous comparator output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seco_m <= 1'b0;
            seco_s <= 1'b0;
        end else begin
            seco_m <= seco;
            seco_s <= seco_m;
        end
    end

    // Debounce: the filtered level follows seco_s only after it has disagreed for
    // DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seco_db <= 1'b0;
            db_cnt  <= 32'd0;
        end else if (seco_s == seco_db) begin
            db_cnt  <= 32'd0;
        end else if (db_cnt == DB_LAST) begin
            seco_db <= seco_s;
            db_cnt  <= 32'd0;
        end else begin
            db_cnt  <= db_cnt + 32'd1;
        end
    end

    // Next-state logic; a disabled system always returns to IDLE and drops the fault.
    // In REGANDO the maximum-time exit is tested first so it wins over a wet reading.
    always_comb begin
        state_nx = state;
        falla_nx = falla_sensor;
        num_nx   = num_riegos;
        if (!habilitar) begin
            state_nx = ST_IDLE;
            falla_nx = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (seco_db) begin
                        state_nx = ST_REGANDO;
                        if (num_riegos != NUM_SAT) begin
                            num_nx = num_riegos + 8'd1;
                        end
                    end
                end
                ST_REGANDO: begin
                    if (t == MAX_LAST) begin
                        state_nx = ST_ESPERA;
                        falla_nx = 1'b1;
                    end else if ((t >= MIN_LAST) && !seco_db) begin
                        state_nx = ST_ESPERA;
                    end
                end
                ST_ESPERA: begin
                    if (t == ESP_LAST) begin
                        state_nx = ST_IDLE;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // The state timer restarts on any state change and whenever the system is disabled.
    assign t_clr = !habilitar || (state_nx != state);

    // State register, state timer and registered outputs; regar mirrors the next state
    // so that it lines up with estado == REGANDO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            t            <= 32'd0;
            regar        <= 1'b0;
            falla_sensor <= 1'b0;
            num_riegos   <= 8'd0;
        end else begin
            state        <= state_nx;
            t            <= t_clr ? 32'd0 : (t + 32'd1);
            regar        <= (state_nx == ST_REGANDO);
            falla_sensor <= falla_nx;
            num_riegos   <= num_nx;
        end
    end

    assign estado = state;

endmodule

// File: tb/tb_control_riego.sv
// tb_control_riego: self-checking bench for control_riego with short timing parameters.
// A reference model runs at every rising edge and queues the expected outputs. A
// monitor on the falling edge pops the queue and compares. Directed scenarios add
// constant checks on top of the model checks.
module tb_control_riego;

  localparam int DB   = 4;
  localparam int MINC = 10;
  localparam int MAXC = 50;
  localparam int ESP  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seco = 1'b0;
  logic       habilitar = 1'b0;
  logic       regar;
  logic [1:0] estado;
  logic       falla_sensor;
  logic [7:0] num_riegos;

  control_riego #(
    .DEBOUNCE_CYC (DB),
    .RIEGO_MIN_CYC(MINC),
    .RIEGO_MAX_CYC(MAXC),
    .ESPERA_CYC   (ESP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seco        (seco),
    .habilitar   (habilitar),
    .regar       (regar),
    .estado      (estado),
    .falla_sensor(falla_sensor),
    .num_riegos  (num_riegos)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // seco samples of the last two edges: the synchronised value seen at an edge is the
  // sample taken two edges earlier.
  bit hist[$];
  bit m_db;
  int m_run;    // consecutive edges where the synchronised input disagreed with m_db
  int m_phase;  // 0 idle, 1 watering, 2 cooldown
  int m_age;    // cycles already spent in the current phase
  bit m_fault;
  int m_num;

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    m_db    = 1'b0;
    m_run   = 0;
    m_phase = 0;
    m_age   = 0;
    m_fault = 1'b0;
    m_num   = 0;
  endtask

  task automatic model_step();
    bit s_seen;
    bit db_seen;
    int done;
    int nxt;
    s_seen = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
    hist.push_back(seco);
    if (hist.size() > 2) void'(hist.pop_front());
    db_seen = m_db;
    // filtered level flips once DB consecutive synchronised samples disagree with it
    if (s_seen == m_db) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == DB) begin
        m_db  = s_seen;
        m_run = 0;
      end
    end
    // phase rules, with done = cycles completed in the phase including this one
    done = m_age + 1;
    nxt  = m_phase;
    if (!habilitar) begin
      nxt     = 0;
      m_fault = 1'b0;
    end else if (m_phase == 0) begin
      if (db_seen) begin
        nxt = 1;
        if (m_num < 255) m_num++;
      end
    end else if (m_phase == 1) begin
      if (done == MAXC) begin
        nxt     = 2;
        m_fault = 1'b1;
      end else if (done >= MINC && !db_seen) begin
        nxt = 2;
      end
    end else begin
      if (done == ESP) nxt = 0;
    end
    if (!habilitar || nxt != m_phase) m_age = 0;
    else m_age++;
    m_phase = nxt;
    exp_q.push_back({(nxt == 1), 2'(nxt), m_fault, 8'(m_num)});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs", {20'd0, regar, estado, falla_sensor, num_riegos}, 32'd0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cycle_outputs", {20'd0, regar, estado, falla_sensor, num_riegos}, {20'd0, e});
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_estado(input logic [1:0] st, input int budget, input string name);
    int k;
    k = 0;
    while (estado !== st && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, {30'd0, estado}, {30'd0, st});
  endtask

  task automatic count_while(input logic [1:0] st, output int n);
    n = 0;
    while (estado === st && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n     = 1'b0;
    seco      = 1'b0;
    habilitar = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 1: short dry glitch never passes the filter
    seco = 1'b1;
    repeat (3) @(negedge clk);
    seco = 1'b0;
    repeat (15) @(negedge clk);
    chk("t1_regar", {31'd0, regar}, 32'd0);
    chk("t1_estado", {30'd0, estado}, 32'd0);
    chk("t1_num", {24'd0, num_riegos}, 32'd0);

    // 2: dry reading starts watering after edge 7; wet at t=3 still waters 10 cycles
    seco = 1'b1;
    repeat (6) @(negedge clk);
    chk("t2_regar_edge6", {31'd0, regar}, 32'd0);
    @(negedge clk);
    chk("t2_regar_edge7", {31'd0, regar}, 32'd1);
    chk("t2_estado_edge7", {30'd0, estado}, 32'd1);
    chk("t2_num", {24'd0, num_riegos}, 32'd1);
    n = 0;
    while (regar === 1'b1 && n < 200) begin
      if (n == 3) seco = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("t2_regar_len", n, MINC);
    count_while(2'd2, n);
    chk("t2_espera_len", n, ESP);
    chk("t2_idle", {30'd0, estado}, 32'd0);

    // 3: soil never wets -> maximum window, fault, cooldown, one idle cycle, re-entry
    seco = 1'b1;
    wait_estado(2'd1, 20, "t3_enter");
    count_while(2'd1, n);
    chk("t3_regar_len", n, MAXC);
    chk("t3_falla", {31'd0, falla_sensor}, 32'd1);
    count_while(2'd2, n);
    chk("t3_espera_len", n, ESP);
    count_while(2'd0, n);
    chk("t3_idle_len", n, 1);
    chk("t3_reenter", {30'd0, estado}, 32'd1);
    chk("t3_num", {24'd0, num_riegos}, 32'd3);
    chk("t3_falla_held", {31'd0, falla_sensor}, 32'd1);

    // 4: disable at t=25 of watering
    repeat (25) @(negedge clk);
    habilitar = 1'b0;
    @(negedge clk);
    chk("t4_regar", {31'd0, regar}, 32'd0);
    chk("t4_estado", {30'd0, estado}, 32'd0);
    chk("t4_falla", {31'd0, falla_sensor}, 32'd0);
    repeat (20) @(negedge clk);
    chk("t4_no_reentry", {30'd0, estado}, 32'd0);
    chk("t4_num_held", {24'd0, num_riegos}, 32'd3);
    habilitar = 1'b1;
    @(negedge clk);
    chk("t4_resume", {30'd0, estado}, 32'd1);
    chk("t4_num", {24'd0, num_riegos}, 32'd4);

    // 5: asynchronous reset in the middle of watering
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_regar", {31'd0, regar}, 32'd0);
    chk("t5_estado", {30'd0, estado}, 32'd0);
    chk("t5_num", {24'd0, num_riegos}, 32'd0);
    chk("t5_falla", {31'd0, falla_sensor}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_estado(2'd1, 20, "t5_resume");
    chk("t5_num_after", {24'd0, num_riegos}, 32'd1);

    // random segments of soil level and enable
    for (int i = 0; i < 150; i++) begin
      seco      = 1'($urandom_range(0, 1));
      habilitar = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    // 6: force about 300 entries through enable toggling; counter saturates
    habilitar = 1'b1;
    seco      = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      habilitar = 1'b1;
      repeat (2) @(negedge clk);
      habilitar = 1'b0;
      @(negedge clk);
    end
    chk("t6_num_sat", {24'd0, num_riegos}, 32'd255);
    habilitar = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_num_final", {24'd0, num_riegos}, 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
